// File: rtl/hazard_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_pkg
//  Shared types and constants for the decode-stage hazard scoreboard.
//  - sb_entry_t  : one in-flight producer record {valid, rd, is_load}.
//                  rd is held at RD_MAX_W bits so the type does not depend
//                  on the register-address width. Narrower addresses are
//                  zero-extended into it.
//  - ctrl_mode_t : the single action taken by the scoreboard in a cycle.
//  - FWD_REGFILE : forward-select code meaning "use the register file value".
// -----------------------------------------------------------------------------
package hazard_scoreboard_pkg;

  localparam int RD_MAX_W = 8;

  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic                is_load;
  } sb_entry_t;

  localparam sb_entry_t SB_INVALID = '0;

  localparam int FWD_REGFILE = 0;

  // Listed from highest to lowest priority.
  typedef enum logic [1:0] {
    MODE_HOLD,
    MODE_FLUSH,
    MODE_STALL,
    MODE_NORMAL
  } ctrl_mode_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_if
//  Groups the decode-side request signals and the pipeline control responses
//  of the hazard scoreboard.
//  master : decode/pipeline side. It drives the dec_* fields, branch_flush
//           and hold_in, and it receives the enables, the bubble, the
//           forward selects and the stall counter.
//  slave  : the scoreboard itself.
//  Signals:
//   dec_valid, dec_rs1/rs2, dec_uses_rs1/rs2, dec_rd, dec_rd_write,
//   dec_is_load, branch_flush, hold_in                   (master -> slave)
//   f_to_d_enable_ff, d_to_e_enable_ff, d_to_e_bubble,
//   pipeline_forward_sel[1:0] ([0]=rs1, [1]=rs2), stall_count (slave -> master)
// -----------------------------------------------------------------------------
interface hazard_scoreboard_if
  import hazard_scoreboard_pkg::*;
#(
  parameter int REGISTER_SIZE = 5,
  parameter int FWD_SEL_SIZE  = 2,
  parameter int STALL_CNT_W   = 16
);

  logic                                dec_valid;
  logic [REGISTER_SIZE-1:0]            dec_rs1;
  logic [REGISTER_SIZE-1:0]            dec_rs2;
  logic                                dec_uses_rs1;
  logic                                dec_uses_rs2;
  logic [REGISTER_SIZE-1:0]            dec_rd;
  logic                                dec_rd_write;
  logic                                dec_is_load;
  logic                                branch_flush;
  logic                                hold_in;

  logic                                f_to_d_enable_ff;
  logic                                d_to_e_enable_ff;
  logic                                d_to_e_bubble;
  logic [1:0][FWD_SEL_SIZE-1:0]        pipeline_forward_sel;
  logic [STALL_CNT_W-1:0]              stall_count;

  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_uses_rs1, dec_uses_rs2,
           dec_rd, dec_rd_write, dec_is_load, branch_flush, hold_in,
    input  f_to_d_enable_ff, d_to_e_enable_ff, d_to_e_bubble,
           pipeline_forward_sel, stall_count
  );

  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_uses_rs1, dec_uses_rs2,
           dec_rd, dec_rd_write, dec_is_load, branch_flush, hold_in,
    output f_to_d_enable_ff, d_to_e_enable_ff, d_to_e_bubble,
           pipeline_forward_sel, stall_count
  );

endinterface

// File: rtl/hazard_scoreboard_forward_select.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_forward_select
//  Combinational priority match of one source operand against the tracked
//  producers. The youngest matching stage (lowest index) wins.
//  - A ready winner selects its stage index.
//  - A winner that is a load still too close to decode raises stall_req and
//    selects the register file.
//  Ports:
//   entries   in  tracked producers, index 1 = execute ... PIPE_DEPTH = writeback
//   dec_valid in  decode holds a real instruction
//   src       in  source register address
//   uses_src  in  operand is actually read
//   sel       out forward select (FWD_REGFILE when no forward applies)
//   stall_req out youngest match is a load that cannot be forwarded yet
// -----------------------------------------------------------------------------
module hazard_scoreboard_forward_select
  import hazard_scoreboard_pkg::*;
#(
  parameter int REGISTER_SIZE = 5,
  parameter int PIPE_DEPTH    = 3,
  parameter int LOAD_LATENCY  = 1,
  parameter int FWD_SEL_SIZE  = 2
) (
  input  sb_entry_t [PIPE_DEPTH:1]  entries,
  input  logic                      dec_valid,
  input  logic [REGISTER_SIZE-1:0]  src,
  input  logic                      uses_src,
  output logic [FWD_SEL_SIZE-1:0]   sel,
  output logic                      stall_req
);

  logic [RD_MAX_W-1:0] src_ext;
  logic                src_live;
  logic [PIPE_DEPTH:1] match;
  logic [PIPE_DEPTH:1] ready;

  always_comb begin
    src_ext = '0;
    src_ext[REGISTER_SIZE-1:0] = src;
  end

  // x0 never creates a dependency, and neither does an unread operand.
  assign src_live = dec_valid & uses_src & (src != '0);

  genvar gi;
  generate
    for (gi = 1; gi <= PIPE_DEPTH; gi++) begin : g_stage
      assign match[gi] = src_live & entries[gi].valid & (entries[gi].rd == src_ext);
      // A load result exists only once it has moved past LOAD_LATENCY stages.
      assign ready[gi] = ~entries[gi].is_load | (gi > LOAD_LATENCY);
    end
  endgenerate

  // Scan oldest to youngest so that the youngest match is applied last.
  always_comb begin
    sel       = FWD_SEL_SIZE'(FWD_REGFILE);
    stall_req = 1'b0;
    for (int k = PIPE_DEPTH; k >= 1; k--) begin
      if (match[k]) begin
        sel       = ready[k] ? FWD_SEL_SIZE'(k) : FWD_SEL_SIZE'(FWD_REGFILE);
        stall_req = ~ready[k];
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//  Decode-stage hazard unit. It tracks PIPE_DEPTH in-flight producers after
//  decode and, in each cycle, produces:
//  - the operand forward selects,
//  - the load-use stall,
//  - the branch-flush bubble,
//  - the external hold.
//  Cycle priority: hold_in > branch_flush > load-use stall > normal issue.
//  Ports:
//   clk  in  clock, rising edge
//   rst  in  asynchronous active-low reset
//   sb   hazard_scoreboard_if.slave:
//        decode request fields in; pipeline enables, bubble, forward selects
//        and the saturating load-use stall counter out.
// -----------------------------------------------------------------------------
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REGISTER_SIZE = 5,
  parameter int PIPE_DEPTH    = 3,
  parameter int LOAD_LATENCY  = 1,
  parameter int FWD_SEL_SIZE  = $clog2(PIPE_DEPTH + 1),
  parameter int STALL_CNT_W   = 16
) (
  input logic               clk,
  input logic               rst,
  hazard_scoreboard_if.slave sb
);

  sb_entry_t [PIPE_DEPTH:1]     entries_reg;
  sb_entry_t [PIPE_DEPTH:1]     entries_next;
  logic [STALL_CNT_W-1:0]       count_reg;
  logic [STALL_CNT_W-1:0]       count_next;

  logic [1:0][REGISTER_SIZE-1:0] src_addr;
  logic [1:0]                    src_uses;
  logic [1:0][FWD_SEL_SIZE-1:0]  sel_raw;
  logic [1:0]                    stall_req;

  ctrl_mode_t                    mode;
  sb_entry_t                     issue_entry;
  logic [RD_MAX_W-1:0]           rd_ext;
  logic                          bubble;

  assign src_addr[0] = sb.dec_rs1;
  assign src_addr[1] = sb.dec_rs2;
  assign src_uses[0] = sb.dec_uses_rs1;
  assign src_uses[1] = sb.dec_uses_rs2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      hazard_scoreboard_forward_select #(
        .REGISTER_SIZE (REGISTER_SIZE),
        .PIPE_DEPTH    (PIPE_DEPTH),
        .LOAD_LATENCY  (LOAD_LATENCY),
        .FWD_SEL_SIZE  (FWD_SEL_SIZE)
      ) u_fwd (
        .entries   (entries_reg),
        .dec_valid (sb.dec_valid),
        .src       (src_addr[gi]),
        .uses_src  (src_uses[gi]),
        .sel       (sel_raw[gi]),
        .stall_req (stall_req[gi])
      );
    end
  endgenerate

  always_comb begin
    mode = MODE_NORMAL;
    if (sb.hold_in) begin
      mode = MODE_HOLD;
    end else if (sb.branch_flush) begin
      mode = MODE_FLUSH;
    end else if (|stall_req) begin
      mode = MODE_STALL;
    end
  end

  always_comb begin
    rd_ext = '0;
    rd_ext[REGISTER_SIZE-1:0] = sb.dec_rd;
  end

  // A write to x0 is never tracked, so x0 can never be forwarded.
  always_comb begin
    issue_entry         = SB_INVALID;
    issue_entry.valid   = sb.dec_valid & sb.dec_rd_write & (sb.dec_rd != '0);
    issue_entry.rd      = rd_ext;
    issue_entry.is_load = sb.dec_is_load;
  end

  always_comb begin
    sb.f_to_d_enable_ff = 1'b1;
    sb.d_to_e_enable_ff = 1'b1;
    bubble              = 1'b0;
    entries_next        = entries_reg;
    count_next          = count_reg;

    // Every mode except hold advances the producers by one stage.
    // The oldest entry then retires.
    if (mode != MODE_HOLD) begin
      for (int k = PIPE_DEPTH; k >= 2; k--) begin
        entries_next[k] = entries_reg[k-1];
      end
    end

    case (mode)
      MODE_HOLD: begin
        sb.f_to_d_enable_ff = 1'b0;
        sb.d_to_e_enable_ff = 1'b0;
      end
      MODE_FLUSH: begin
        bubble          = 1'b1;
        entries_next[1] = SB_INVALID;
      end
      MODE_STALL: begin
        sb.f_to_d_enable_ff = 1'b0;
        bubble              = 1'b1;
        entries_next[1]     = SB_INVALID;
        if (~&count_reg) begin
          count_next = count_reg + 1'b1;
        end
      end
      default: begin
        entries_next[1] = issue_entry;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entries_reg <= '0;
      count_reg   <= '0;
    end else begin
      entries_reg <= entries_next;
      count_reg   <= count_next;
    end
  end

  // Selects are meaningless under a bubble. They are forced to the register
  // file so that the output stays deterministic.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      sb.pipeline_forward_sel[k] = bubble ? FWD_SEL_SIZE'(FWD_REGFILE) : sel_raw[k];
    end
  end

  assign sb.d_to_e_bubble = bubble;
  assign sb.stall_count   = count_reg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  localparam int RS  = 5;
  localparam int PD  = 3;
  localparam int LL  = 1;
  localparam int FW  = $clog2(PD + 1);
  localparam int CW  = 16;
  localparam int CWS = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REGISTER_SIZE(RS), .FWD_SEL_SIZE(FW), .STALL_CNT_W(CW))  sif ();
  hazard_scoreboard_if #(.REGISTER_SIZE(RS), .FWD_SEL_SIZE(FW), .STALL_CNT_W(CWS)) sif_s ();

  // The narrow-counter instance sees the same stimulus.
  assign sif_s.dec_valid    = sif.dec_valid;
  assign sif_s.dec_rs1      = sif.dec_rs1;
  assign sif_s.dec_rs2      = sif.dec_rs2;
  assign sif_s.dec_uses_rs1 = sif.dec_uses_rs1;
  assign sif_s.dec_uses_rs2 = sif.dec_uses_rs2;
  assign sif_s.dec_rd       = sif.dec_rd;
  assign sif_s.dec_rd_write = sif.dec_rd_write;
  assign sif_s.dec_is_load  = sif.dec_is_load;
  assign sif_s.branch_flush = sif.branch_flush;
  assign sif_s.hold_in      = sif.hold_in;

  hazard_scoreboard #(
    .REGISTER_SIZE(RS), .PIPE_DEPTH(PD), .LOAD_LATENCY(LL),
    .FWD_SEL_SIZE(FW), .STALL_CNT_W(CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sif)
  );

  hazard_scoreboard #(
    .REGISTER_SIZE(RS), .PIPE_DEPTH(PD), .LOAD_LATENCY(LL),
    .FWD_SEL_SIZE(FW), .STALL_CNT_W(CWS)
  ) dut_s (
    .clk (clk),
    .rst (rst),
    .sb  (sif_s)
  );

  // Reference model: in-flight producers, where index k is the stage k after decode.
  bit m_v  [1:PD];
  int m_rd [1:PD];
  bit m_ld [1:PD];
  int exp_cnt;
  int exp_cnt_s;

  // Current decode request.
  bit c_v, c_u1, c_u2, c_wr, c_ld, c_fl, c_hd;
  int c_rs1, c_rs2, c_rd;

  // Expected outputs for the current cycle.
  bit e_f, e_d, e_b, e_stall;
  int e_sel0, e_sel1;

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 1; k <= PD; k++) begin
      m_v[k] = 0; m_rd[k] = 0; m_ld[k] = 0;
    end
    exp_cnt   = 0;
    exp_cnt_s = 0;
  endfunction

  // Youngest producer of src decides: forward from it, or wait if it is a young load.
  function automatic void fwd(input int src, input bit uses, output int sel, output bit stall);
    sel   = 0;
    stall = 0;
    if (!(c_v && uses && src != 0)) return;
    for (int k = 1; k <= PD; k++) begin
      if (m_v[k] && m_rd[k] == src) begin
        if (m_ld[k] && k <= LL) stall = 1;
        else sel = k;
        return;
      end
    end
  endfunction

  function automatic void model_outputs();
    int s0, s1;
    bit st0, st1;
    fwd(c_rs1, c_u1, s0, st0);
    fwd(c_rs2, c_u2, s1, st1);
    e_stall = st0 | st1;
    if (c_hd) begin
      e_f = 0; e_d = 0; e_b = 0; e_sel0 = s0; e_sel1 = s1;
    end else if (c_fl || e_stall) begin
      e_f = c_fl; e_d = 1; e_b = 1; e_sel0 = 0; e_sel1 = 0;
    end else begin
      e_f = 1; e_d = 1; e_b = 0; e_sel0 = s0; e_sel1 = s1;
    end
  endfunction

  function automatic void model_update();
    if (c_hd) return;
    for (int k = PD; k >= 2; k--) begin
      m_v[k] = m_v[k-1]; m_rd[k] = m_rd[k-1]; m_ld[k] = m_ld[k-1];
    end
    if (c_fl || e_stall) begin
      m_v[1] = 0; m_rd[1] = 0; m_ld[1] = 0;
    end else begin
      m_v[1] = c_v && c_wr && c_rd != 0; m_rd[1] = c_rd; m_ld[1] = c_ld;
    end
    if (!c_fl && e_stall) begin
      if (exp_cnt < (1 << CW) - 1) exp_cnt++;
      if (exp_cnt_s < (1 << CWS) - 1) exp_cnt_s++;
    end
  endfunction

  task automatic check_all();
    chk("f_to_d", 32'(sif.f_to_d_enable_ff), 32'(e_f));
    chk("d_to_e", 32'(sif.d_to_e_enable_ff), 32'(e_d));
    chk("bubble", 32'(sif.d_to_e_bubble), 32'(e_b));
    chk("sel_rs1", 32'(sif.pipeline_forward_sel[0]), 32'(e_sel0));
    chk("sel_rs2", 32'(sif.pipeline_forward_sel[1]), 32'(e_sel1));
    chk("stall_count", 32'(sif.stall_count), 32'(exp_cnt));
    chk("stall_count_narrow", 32'(sif_s.stall_count), 32'(exp_cnt_s));
  endtask

  task automatic drive(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                       input int rd, input bit wr, input bit ld, input bit fl, input bit hd);
    c_v = v; c_rs1 = rs1; c_u1 = u1; c_rs2 = rs2; c_u2 = u2;
    c_rd = rd; c_wr = wr; c_ld = ld; c_fl = fl; c_hd = hd;
    sif.dec_valid    = v;
    sif.dec_rs1      = rs1[RS-1:0];
    sif.dec_uses_rs1 = u1;
    sif.dec_rs2      = rs2[RS-1:0];
    sif.dec_uses_rs2 = u2;
    sif.dec_rd       = rd[RS-1:0];
    sif.dec_rd_write = wr;
    sif.dec_is_load  = ld;
    sif.branch_flush = fl;
    sif.hold_in      = hd;
    #1;
    model_outputs();
    $display("cycle t=%0t v=%0d rs1=%0d/%0d rs2=%0d/%0d rd=%0d wr=%0d ld=%0d fl=%0d hd=%0d -> f=%0d d=%0d b=%0d sel=%0d,%0d cnt=%0d",
             $time, v, rs1, u1, rs2, u2, rd, wr, ld, fl, hd, sif.f_to_d_enable_ff,
             sif.d_to_e_enable_ff, sif.d_to_e_bubble, sif.pipeline_forward_sel[0],
             sif.pipeline_forward_sel[1], sif.stall_count);
    check_all();
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_update();
    @(negedge clk);
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic prod(input int rd, input bit ld);
    drive(1, 0, 0, 0, 0, rd, 1, ld, 0, 0);
    tick();
  endtask

  initial begin
    model_reset();
    c_v = 0; c_u1 = 0; c_u2 = 0; c_wr = 0; c_ld = 0; c_fl = 0; c_hd = 0;
    c_rs1 = 0; c_rs2 = 0; c_rd = 0;
    sif.dec_valid = 0; sif.dec_rs1 = '0; sif.dec_rs2 = '0;
    sif.dec_uses_rs1 = 0; sif.dec_uses_rs2 = 0; sif.dec_rd = '0;
    sif.dec_rd_write = 0; sif.dec_is_load = 0; sif.branch_flush = 0; sif.hold_in = 0;

    // Reset state.
    #1;
    chk("rst_f_to_d", 32'(sif.f_to_d_enable_ff), 32'd1);
    chk("rst_d_to_e", 32'(sif.d_to_e_enable_ff), 32'd1);
    chk("rst_bubble", 32'(sif.d_to_e_bubble), 32'd0);
    chk("rst_sel", 32'(sif.pipeline_forward_sel), 32'd0);
    chk("rst_count", 32'(sif.stall_count), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // add x5, then add x6,x5,x5.
    prod(5, 0);
    drive(1, 5, 1, 5, 1, 6, 1, 0, 0, 0);
    chk("alu_sel_rs1", 32'(sif.pipeline_forward_sel[0]), 32'd1);
    chk("alu_sel_rs2", 32'(sif.pipeline_forward_sel[1]), 32'd1);
    chk("alu_no_stall", 32'(sif.f_to_d_enable_ff), 32'd1);
    tick();

    // lw x7, then add x8,x7,x0.
    nop(); nop(); nop();
    prod(7, 1);
    drive(1, 7, 1, 0, 1, 8, 1, 0, 0, 0);
    chk("lu_f_to_d", 32'(sif.f_to_d_enable_ff), 32'd0);
    chk("lu_bubble", 32'(sif.d_to_e_bubble), 32'd1);
    tick();
    chk("lu_count", 32'(sif.stall_count), 32'd1);
    drive(1, 7, 1, 0, 1, 8, 1, 0, 0, 0);
    chk("lu_fwd_sel", 32'(sif.pipeline_forward_sel[0]), 32'd2);
    chk("lu_resume", 32'(sif.f_to_d_enable_ff), 32'd1);
    tick();

    // An x0 producer never forwards, and an unread operand never forwards.
    prod(0, 0);
    drive(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    chk("x0_sel_rs1", 32'(sif.pipeline_forward_sel[0]), 32'd0);
    chk("x0_sel_rs2", 32'(sif.pipeline_forward_sel[1]), 32'd0);
    tick();
    prod(10, 0);
    drive(1, 0, 0, 10, 0, 0, 0, 0, 0, 0);
    chk("unused_rs2_sel", 32'(sif.pipeline_forward_sel[1]), 32'd0);
    tick();

    // With two producers of x9, the youngest one wins.
    nop(); nop(); nop();
    prod(9, 0); nop(); prod(9, 0);
    drive(1, 9, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("youngest_sel", 32'(sif.pipeline_forward_sel[0]), 32'd1);
    tick();
    nop(); nop(); nop();
    prod(9, 0); nop(); nop();
    drive(1, 9, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("wb_stage_sel", 32'(sif.pipeline_forward_sel[0]), 32'd3);
    tick();

    // A flush wins over a stall in the same cycle.
    nop(); nop(); nop();
    prod(11, 1);
    drive(1, 11, 1, 0, 0, 0, 0, 0, 1, 0);
    chk("flush_f_to_d", 32'(sif.f_to_d_enable_ff), 32'd1);
    chk("flush_bubble", 32'(sif.d_to_e_bubble), 32'd1);
    tick();
    chk("flush_count", 32'(sif.stall_count), 32'd1);

    // Hold for three cycles.
    nop(); nop(); nop();
    prod(12, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 12, 1, 0, 0, 0, 0, 0, 0, 1);
      chk("hold_f_to_d", 32'(sif.f_to_d_enable_ff), 32'd0);
      chk("hold_d_to_e", 32'(sif.d_to_e_enable_ff), 32'd0);
      chk("hold_sel", 32'(sif.pipeline_forward_sel[0]), 32'd1);
      tick();
    end
    drive(1, 12, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("post_hold_sel", 32'(sif.pipeline_forward_sel[0]), 32'd1);
    tick();

    // Reset asserted during a stall.
    nop(); nop(); nop();
    prod(13, 1);
    drive(1, 13, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("pre_rst_stall", 32'(sif.f_to_d_enable_ff), 32'd0);
    rst = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_f_to_d", 32'(sif.f_to_d_enable_ff), 32'd1);
    chk("mid_rst_bubble", 32'(sif.d_to_e_bubble), 32'd0);
    chk("mid_rst_count", 32'(sif.stall_count), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Saturation: 20 stalls alternate with issues. The narrow counter stops at 15.
    for (int i = 0; i < 40; i++) begin
      drive(1, 14, 1, 0, 0, 14, 1, 1, 0, 0);
      tick();
    end
    chk("sat_count_wide", 32'(sif.stall_count), 32'd20);
    chk("sat_count_narrow", 32'(sif_s.stall_count), 32'd15);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) != 0,
            int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
            int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
            int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 11) == 0,
            $urandom_range(0, 9) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
